mr1_dbus_sram_bridge: RTL and testbench

Data-side memory responder for the MR1 core: consumes the core's `data_req_*` request stream and produces `data_rsp_*` responses by driving a single-port synchronous SRAM with byte enables. It is the stage directly downstream of the core's data bus, both in the formal/simulation harness and on FPGA builds. It handles one outstanding transaction, byte-lane steering for stores, lane extraction for loads, and misaligned-access detection.

---
 rtl/mr1_dbus_pkg.sv | 15 +
 rtl/mr1_dbus_lane.sv | 43 ++++
 rtl/mr1_dbus_sram_bridge.sv | 155 +++++++++++++++
 tb/tb_mr1_dbus_sram_bridge.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mr1_dbus_pkg.sv
// rtl/mr1_dbus_pkg.sv - MR1 data-bus size encodings and bridge FSM states
package mr1_dbus_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    st_idle,
    st_issue,
    st_wait,
    st_rsp
  } state_t;

endpackage

// File: rtl/mr1_dbus_lane.sv
// rtl/mr1_dbus_lane.sv - byte-lane steering: byte enables, store replication, load extraction
module mr1_dbus_lane
  import mr1_dbus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;

  // Reserved size 3 falls into the word branch; half ignores addr_lo[0].
  always_comb begin
    be         = 4'b1111;
    wdata_out  = wdata_in;
    rdata_out  = rdata_in;
    byte_shift = rdata_in >> {addr_lo, 3'b000};
    half_shift = rdata_in >> {addr_lo[1], 4'b0000};
    case (size)
      SIZE_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_out = {4{wdata_in[7:0]}};
        rdata_out = {24'd0, byte_shift[7:0]};
      end
      SIZE_H: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_out = {2{wdata_in[15:0]}};
        rdata_out = {16'd0, half_shift[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wdata_out = wdata_in;
        rdata_out = rdata_in;
      end
    endcase
  end

endmodule

// File: rtl/mr1_dbus_sram_bridge.sv
// rtl/mr1_dbus_sram_bridge.sv - MR1 data bus to single-port SRAM bridge; MR1_DBUS_MISALIGN_CHECK_EN adds sticky misalign_err
module mr1_dbus_sram_bridge
  import mr1_dbus_pkg::*;
#(
  parameter int SRAM_AW    = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               data_req_valid,
  output logic               data_req_ready,
  input  logic               data_req_wr,
  input  logic [1:0]         data_req_size,
  input  logic [31:0]        data_req_addr,
  input  logic [31:0]        data_req_data,
  output logic               data_rsp_valid,
  output logic [31:0]        data_rsp_data,
  output logic               sram_en,
  output logic               sram_wr,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [3:0]         sram_be,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
`ifdef MR1_DBUS_MISALIGN_CHECK_EN
  ,
  output logic               misalign_err
`endif
);

  localparam int CW = $clog2(RD_LATENCY + 1);

  state_t             state_q, state_d;
  logic               wr_q, wr_d;
  logic [1:0]         size_q, size_d;
  logic [SRAM_AW+1:0] addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic [3:0]         lane_be;
  logic [31:0]        lane_rdata;
  logic               mis;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^data_req_addr[31:SRAM_AW+2];

  mr1_dbus_lane u_lane (
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .wdata_in  (data_q),
    .rdata_in  (sram_rdata),
    .be        (lane_be),
    .wdata_out (sram_wdata),
    .rdata_out (lane_rdata)
  );

  // Address and write data come straight from the latched request so they hold between accesses.
  assign sram_addr     = addr_q[SRAM_AW+1:2];
  assign data_rsp_data = rsp_data_q;

`ifdef MR1_DBUS_MISALIGN_CHECK_EN
  logic err_q, err_d;

  // Half on an odd byte, or word/reserved size off a word boundary, is misaligned.
  always_comb begin
    mis   = ((size_q == SIZE_H) && addr_q[0]) || ((size_q >= SIZE_W) && (addr_q[1:0] != 2'b00));
    err_d = err_q | ((state_q == st_issue) && mis);
  end

  assign misalign_err = err_q;
`else
  assign mis = 1'b0;
`endif

  // Request/response FSM: one outstanding access, strobes only in ISSUE.
  always_comb begin
    state_d        = state_q;
    wr_d           = wr_q;
    size_d         = size_q;
    addr_d         = addr_q;
    data_d         = data_q;
    cnt_d          = cnt_q;
    rsp_data_d     = rsp_data_q;
    data_req_ready = 1'b0;
    data_rsp_valid = 1'b0;
    sram_en        = 1'b0;
    sram_wr        = 1'b0;
    sram_be        = 4'b0000;
    case (state_q)
      st_idle: begin
        data_req_ready = 1'b1;
        if (data_req_valid) begin
          wr_d    = data_req_wr;
          size_d  = data_req_size;
          addr_d  = data_req_addr[SRAM_AW+1:0];
          data_d  = data_req_data;
          state_d = st_issue;
        end
      end
      st_issue: begin
        sram_en = ~mis;
        sram_wr = wr_q & ~mis;
        sram_be = mis ? 4'b0000 : lane_be;
        if (wr_q) begin
          state_d = st_idle;
        end else begin
          cnt_d   = CW'(RD_LATENCY);
          state_d = st_wait;
        end
      end
      st_wait: begin
        // Data is valid on the cycle the counter shows 1; <= guards against a stuck zero.
        if (cnt_q <= CW'(1)) begin
          rsp_data_d = mis ? 32'd0 : lane_rdata;
          state_d    = st_rsp;
        end
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      st_rsp: begin
        data_rsp_valid = 1'b1;
        state_d        = st_idle;
      end
      default: state_d = st_idle;
    endcase
  end

  // State and request registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= st_idle;
      wr_q       <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= '0;
      data_q     <= 32'd0;
      cnt_q      <= '0;
      rsp_data_q <= 32'd0;
`ifdef MR1_DBUS_MISALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
`ifdef MR1_DBUS_MISALIGN_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mr1_dbus_sram_bridge.sv
// tb/tb_mr1_dbus_sram_bridge.sv - scoreboard bench for mr1_dbus_sram_bridge; honours MR1_DBUS_MISALIGN_CHECK_EN
module tb_mr1_dbus_sram_bridge;

  localparam int AW  = 12;
  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          valid, wr;
  logic [1:0]    size;
  logic [31:0]   addr, data;
  logic          data_req_ready, data_rsp_valid;
  logic [31:0]   data_rsp_data;
  logic          sram_en, sram_wr;
  logic [AW-1:0] sram_addr;
  logic [3:0]    sram_be;
  logic [31:0]   sram_wdata, sram_rdata;
  logic          misalign_err;

  logic          v3;
  logic [31:0]   a3;
  logic          ready3, rsp3, en3, wr3o;
  logic [31:0]   rsp_data3, wdata3, rdata3;
  logic [AW-1:0] addr3;
  logic [3:0]    be3;
  logic          err3;

  mr1_dbus_sram_bridge #(.SRAM_AW(AW), .RD_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .data_req_valid(valid), .data_req_ready(data_req_ready), .data_req_wr(wr),
    .data_req_size(size), .data_req_addr(addr), .data_req_data(data),
    .data_rsp_valid(data_rsp_valid), .data_rsp_data(data_rsp_data),
    .sram_en(sram_en), .sram_wr(sram_wr), .sram_addr(sram_addr), .sram_be(sram_be),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
`ifdef MR1_DBUS_MISALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  mr1_dbus_sram_bridge #(.SRAM_AW(AW), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .data_req_valid(v3), .data_req_ready(ready3), .data_req_wr(1'b0),
    .data_req_size(2'd2), .data_req_addr(a3), .data_req_data(32'd0),
    .data_rsp_valid(rsp3), .data_rsp_data(rsp_data3),
    .sram_en(en3), .sram_wr(wr3o), .sram_addr(addr3), .sram_be(be3),
    .sram_wdata(wdata3), .sram_rdata(rdata3)
`ifdef MR1_DBUS_MISALIGN_CHECK_EN
    , .misalign_err(err3)
`endif
  );

`ifndef MR1_DBUS_MISALIGN_CHECK_EN
  assign misalign_err = 1'b0;
  assign err3         = 1'b0;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_mis(input logic [1:0] s, input logic [1:0] a);
`ifdef MR1_DBUS_MISALIGN_CHECK_EN
    return (s == 2'd1 && a[0]) || (s >= 2'd2 && a != 2'd0);
`else
    return (s == 2'd3) && (a == 2'd3) && 1'b0;
`endif
  endfunction

  // SRAM models: memory written by DUT strobes, and reference memory written by the model.
  logic [31:0] sram_mem [0:4095];
  logic [31:0] ref_mem  [0:4095];
  logic [31:0] pipe     [0:LAT-1];
  logic [31:0] p3       [0:2];

  assign sram_rdata = pipe[LAT-1];
  assign rdata3     = p3[2];

  always @(posedge clk) begin
    if (sram_en && sram_wr)
      for (int b = 0; b < 4; b++)
        if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    pipe[0] <= (sram_en && !sram_wr) ? sram_mem[sram_addr] : 32'hBAD0_0BAD;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    p3[0] <= (en3 && !wr3o) ? sram_mem[addr3] : 32'hBAD3_3BAD;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  typedef struct {
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t        exp_q[$];
  int          busy_until = 0;
  int          issue_cyc  = -1;
  logic        iss_mis, iss_wr;
  logic [AW-1:0] iss_addr;
  logic [3:0]  iss_be;
  logic [31:0] iss_wdata;
  logic [31:0] last_rsp = 32'd0;
  logic        exp_err = 1'b0;

  // Monitor: compares every DUT output each cycle against the model.
  always @(negedge clk) begin
    int nb, base;
    logic [1:0] a;
    logic [AW-1:0] widx;
    exp_t e;
    if (!reset_n) begin
      exp_q.delete();
      busy_until = 0;
      issue_cyc  = -1;
      last_rsp   = 32'd0;
      exp_err    = 1'b0;
    end else begin
      if (data_rsp_valid) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_data", data_rsp_data, e.data);
          chk("rsp_cycle", cyc, e.at);
          last_rsp = e.data;
        end
      end else begin
        chk("rsp_data_hold", data_rsp_data, last_rsp);
      end
      chk("req_ready", {31'd0, data_req_ready}, {31'd0, cyc >= busy_until});
      if (cyc == issue_cyc) begin
        chk("sram_en_issue", {31'd0, sram_en}, {31'd0, !iss_mis});
        if (!iss_mis) begin
          chk("sram_addr", {20'd0, sram_addr}, {20'd0, iss_addr});
          chk("sram_wr", {31'd0, sram_wr}, {31'd0, iss_wr});
          chk("sram_be", {28'd0, sram_be}, {28'd0, iss_be});
          if (iss_wr) chk("sram_wdata", sram_wdata, iss_wdata);
        end
      end else begin
        chk("sram_en_quiet", {31'd0, sram_en}, 32'd0);
        chk("sram_wr_quiet", {31'd0, sram_wr}, 32'd0);
        chk("sram_be_quiet", {28'd0, sram_be}, 32'd0);
      end
`ifdef MR1_DBUS_MISALIGN_CHECK_EN
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, exp_err});
`endif
      if (cyc == issue_cyc && iss_mis) exp_err = 1'b1;

      if (valid && data_req_ready) begin
        a    = addr[1:0];
        widx = addr[AW+1:2];
        nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        base = (size == 2'd0) ? int'(a) : (size == 2'd1) ? int'(a & 2'd2) : 0;
        iss_mis   = is_mis(size, a);
        iss_wr    = wr;
        iss_addr  = widx;
        issue_cyc = cyc + 1;
        iss_be    = 4'd0;
        for (int b = 0; b < 4; b++) begin
          iss_wdata[8*b +: 8] = data[8*(b % nb) +: 8];
          if (b >= base && b < base + nb) iss_be[b] = 1'b1;
        end
        if (wr) begin
          busy_until = cyc + 2;
          if (!iss_mis)
            for (int k = 0; k < nb; k++) ref_mem[widx][8*(base+k) +: 8] = data[8*k +: 8];
        end else begin
          busy_until = cyc + 3 + LAT;
          e.data = 32'd0;
          if (!iss_mis)
            for (int k = 0; k < nb; k++) e.data[8*k +: 8] = ref_mem[widx][8*(base+k) +: 8];
          e.at = cyc + 2 + LAT;
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic do_req(input logic w, input logic [1:0] s, input logic [31:0] ad, input logic [31:0] d);
    int guard;
    valid = 1'b1; wr = w; size = s; addr = ad; data = d;
    guard = 0;
    forever begin
      @(negedge clk);
      if (data_req_ready) break;
      guard++;
      if (guard > 50) begin
        chk("req_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    reset_n = 1'b0; valid = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0; data = 32'd0;
    v3 = 1'b0; a3 = 32'd0;
    for (int i = 0; i < 4096; i++) begin
      w = $urandom;
      sram_mem[i] = w;
      ref_mem[i]  = w;
    end
    sram_mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    sram_mem[1] = 32'h1234ABCD; ref_mem[1] = 32'h1234ABCD;
    #1;
    chk("rst_ready", {31'd0, data_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, data_rsp_valid}, 32'd0);
    chk("rst_rsp_data", data_rsp_data, 32'd0);
    chk("rst_sram_en", {31'd0, sram_en}, 32'd0);
    chk("rst_sram_addr", {20'd0, sram_addr}, 32'd0);
    chk("rst_sram_wdata", sram_wdata, 32'd0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
    chk("rst_ready3", {31'd0, ready3}, 32'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    do_req(1'b0, 2'd2, 32'h10, 32'd0);
    do_req(1'b1, 2'd0, 32'h23, 32'h000000A5);
    do_req(1'b0, 2'd1, 32'h06, 32'd0);
    do_req(1'b0, 2'd2, 32'h20, 32'd0);
    do_req(1'b1, 2'd1, 32'h0E, 32'hFFFF5A6B);
    do_req(1'b0, 2'd3, 32'h0C, 32'd0);
`ifdef MR1_DBUS_MISALIGN_CHECK_EN
    do_req(1'b0, 2'd2, 32'h02, 32'd0);
    do_req(1'b0, 2'd2, 32'h10, 32'd0);
    do_req(1'b1, 2'd1, 32'h05, 32'h0000BEEF);
`endif

    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)), $urandom);
    end

    // Reset while a load sits in WAIT.
    do_req(1'b0, 2'd2, 32'h10, 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, data_req_ready}, 32'd1);
    chk("arst_rsp_valid", {31'd0, data_rsp_valid}, 32'd0);
    chk("arst_rsp_data", data_rsp_data, 32'd0);
    chk("arst_sram_en", {31'd0, sram_en}, 32'd0);
    chk("arst_sram_be", {28'd0, sram_be}, 32'd0);
    chk("arst_sram_addr", {20'd0, sram_addr}, 32'd0);
    chk("arst_sram_wdata", sram_wdata, 32'd0);
    chk("arst_misalign", {31'd0, misalign_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // RD_LATENCY=3 instance with a request held valid across the busy window.
    v3 = 1'b1; a3 = 32'h10;
    @(negedge clk);
    chk("lat3_ready_T", {31'd0, ready3}, 32'd1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("lat3_ready", {31'd0, ready3}, {31'd0, (k == 6 || k == 12)});
      chk("lat3_rsp_valid", {31'd0, rsp3}, {31'd0, (k == 5 || k == 11)});
      if (k == 5 || k == 11) chk("lat3_rsp_data", rsp_data3, ref_mem[4]);
      if (k == 6) begin
        @(posedge clk); #1;
        v3 = 1'b0;
      end
    end

    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("pending_rsp", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
